muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle integer multiply/divide sequencer for the SCPU execute stage. It time-shares one 33-bit add/sub datapath across W iterations: shift-add for multiply, restoring for divide. It accepts one operation at a time from the control unit, holds busy while iterating, and returns a 2W-bit result as hi/lo with a one-cycle done pulse.

## Interface
- W, default 32: operand width; iteration count equals W.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- op  in  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- a  in  W  multiplicand or dividend; sampled at the accept edge.
- b  in  W  multiplier or divisor; sampled at the accept edge.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; hi, lo and div_zero are valid from this cycle.
- hi  out  W  MUL: product[2W-1:W]. DIV: remainder.
- lo  out  W  MUL: product[W-1:0]. DIV: quotient.
- div_zero  out  1  divisor was 0; qualified by done.

## Operation
- States: IDLE, CALC, FIX.
- IDLE to CALC on start.
  - Latch op, sa=a[W-1], sb=b[W-1].
  - Load magnitudes: |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Clear iteration counter.
- CALC, MUL, per cycle:
  - If P[0]=1, P[2W:W] = P[2W-1:W] + mcand. This is a (W+1)-bit add with carry kept.
  - Then shift P right by 1.
- CALC, DIV, per cycle:
  - Shift {R,Q} left by 1.
  - Compute T = R − divisor as a (W+1)-bit sub: add ~B with carry-in 1.
  - No borrow: R=T and Q[0]=1. Borrow: R unchanged and Q[0]=0.
- CALC to FIX after the W-th iteration, when counter = W−1.
- FIX, one cycle, then go to IDLE:
  - Signed MUL with sa^sb: negate the 2W-bit product.
  - Signed DIV: negate the quotient if sa^sb; negate the remainder if sa.
  - Write hi and lo, pulse done.
- Divisor 0: skip sign fix. Result is lo = all ones, hi = original a, div_zero=1.
- Signed overflow: DIV of −2^(W−1) by −1 gives lo=0x80000000, hi=0. No flag.
- start while busy is ignored. Operands are not re-sampled.
- hi, lo and div_zero hold their last values until the next FIX.
- All add/sub arithmetic is W+1 bits wide. The carry/borrow is bit W.

## Timing
- Reset, asynchronous: state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0. All work registers are cleared.
- start sampled high at edge 0:
  - busy=1 from edge 0 to edge W+1 (W+1 cycles).
  - done=1 for one cycle after edge W+1.
  - Latency from the start cycle to the done cycle is W+2 cycles (34 for W=32).
- done and busy are never both high.
- start in the done cycle is accepted: back-to-back throughput is one op per W+2 cycles.
- rst_n low mid-operation aborts immediately. No done is produced, and outputs go to their reset values.

## Configuration
- MULDIV_SIGNED_EN defined:
  - op[0] selects signed handling.
  - Magnitude load and FIX sign correction are present.
- MULDIV_SIGNED_EN undefined:
  - op[0] is ignored, so MUL behaves as MULU and DIV behaves as DIVU.
  - Sign capture and negation logic are not generated.
  - Timing is unchanged.

## Structure
- muldiv_pkg holds:
  - op encodings: OP_MULU, OP_MUL, OP_DIVU, OP_DIV;
  - state encodings: ST_IDLE, ST_CALC, ST_FIX;
  - default W.
- Sub-module muldiv_addsub: combinational (W+1)-bit adder, S = A + (sub ? ~B : B) + sub.
  - This is the shared resource. Exactly one instance exists, and both algorithms drive it through operand muxes.

## Test plan
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done exactly 34 cycles after the start cycle.
- MUL a=0xFFFFFFFD (−3), b=7:
  - with macro → hi=0xFFFFFFFF, lo=0xFFFFFFEB;
  - without macro → hi=0x00000006, lo=0xFFFFFFEB.
- DIVU a=100, b=7 → lo=14, hi=2. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, div_zero=1 with done.
- Busy handling:
  - start pulsed at cycle 5 of a busy op → ignored, and the first result is unchanged.
  - rst_n low at cycle 10 → busy=0 at once, no done.
  - A subsequent MULU 3×4 → lo=12.
- start held high through done → the second op is accepted in the done cycle, and its done arrives 34 cycles later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and the default operand width for muldiv_seq.
package muldiv_pkg;

    localparam int MULDIV_W = 32;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: the single (W+1)-bit add/sub shared by multiply and divide.
// Subtraction is A + ~B + 1, so bit W of s is the borrow indicator.
module muldiv_addsub
    import muldiv_pkg::*;
#(
    parameter int W = MULDIV_W
) (
    input  logic [W:0] a,
    input  logic [W:0] b,
    input  logic       sub,
    output logic [W:0] s
);

    assign s = a + (sub ? ~b : b) + {{W{1'b0}}, sub};

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle shift-add multiply / restoring divide sequencer.
// Signed MUL/DIV handling is generated only when MULDIV_SIGNED_EN is defined.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int W = MULDIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_zero
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 32'd1);

    logic [1:0]    state_r;
    logic          busy_r;
    logic          done_r;
    logic [W-1:0]  hi_r;
    logic [W-1:0]  lo_r;
    logic          div_zero_r;
    logic          is_div_r;
    logic          dz_r;
    logic [W-1:0]  acc_r;
    logic [W-1:0]  low_r;
    logic [W-1:0]  opb_r;
    logic [W-1:0]  a_orig_r;
    logic [CW-1:0] cnt_r;

    logic [W-1:0]   mag_a_s;
    logic [W-1:0]   mag_b_s;
    logic [W:0]     add_a_s;
    logic [W:0]     add_b_s;
    logic           add_sub_s;
    logic [W:0]     add_s;
    logic [W-1:0]   acc_nx_s;
    logic [W-1:0]   low_nx_s;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   res_hi_s;
    logic [W-1:0]   res_lo_s;
    logic           res_dz_s;

`ifdef MULDIV_SIGNED_EN
    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    logic sgn_r;
    logic sa_r;
    logic sb_r;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
        return ~x + ONE_2W;
    endfunction
`else
    logic unused_op0_s;
    assign unused_op0_s = op[0];
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign div_zero = div_zero_r;

    // Operand magnitudes captured at the accept edge
    always_comb begin
        mag_a_s = a;
        mag_b_s = b;
`ifdef MULDIV_SIGNED_EN
        if (op[0] == 1'b1) begin
            mag_a_s = a[W-1] ? neg_w(a) : a;
            mag_b_s = b[W-1] ? neg_w(b) : b;
        end else begin
            mag_a_s = a;
            mag_b_s = b;
        end
`endif
    end

    // Operand muxes into the shared adder: {R,Q} shifted minus divisor, or P-high plus mcand
    always_comb begin
        add_a_s   = {(W+1){1'b0}};
        add_b_s   = {(W+1){1'b0}};
        add_sub_s = 1'b0;
        if (is_div_r) begin
            add_a_s   = {acc_r, low_r[W-1]};
            add_b_s   = {1'b0, opb_r};
            add_sub_s = 1'b1;
        end else begin
            add_a_s   = {1'b0, acc_r};
            add_b_s   = low_r[0] ? {1'b0, opb_r} : {(W+1){1'b0}};
            add_sub_s = 1'b0;
        end
    end

    muldiv_addsub #(.W(W)) u_addsub (
        .a   (add_a_s),
        .b   (add_b_s),
        .sub (add_sub_s),
        .s   (add_s)
    );

    // One iteration step; a borrow in bit W keeps the shifted remainder
    always_comb begin
        acc_nx_s = acc_r;
        low_nx_s = low_r;
        if (is_div_r) begin
            if (add_s[W]) begin
                acc_nx_s = add_a_s[W-1:0];
                low_nx_s = {low_r[W-2:0], 1'b0};
            end else begin
                acc_nx_s = add_s[W-1:0];
                low_nx_s = {low_r[W-2:0], 1'b1};
            end
        end else begin
            acc_nx_s = add_s[W:1];
            low_nx_s = {add_s[0], low_r[W-1:1]};
        end
    end

    // Final hi/lo with sign correction and the divide-by-zero override
    always_comb begin
        prod_s   = {acc_r, low_r};
        res_hi_s = acc_r;
        res_lo_s = low_r;
        res_dz_s = 1'b0;
        if (is_div_r) begin
            if (dz_r) begin
                res_hi_s = a_orig_r;
                res_lo_s = {W{1'b1}};
                res_dz_s = 1'b1;
            end else begin
                res_hi_s = acc_r;
                res_lo_s = low_r;
                res_dz_s = 1'b0;
`ifdef MULDIV_SIGNED_EN
                if (sgn_r && (sa_r ^ sb_r)) begin
                    res_lo_s = neg_w(low_r);
                end else begin
                    res_lo_s = low_r;
                end
                if (sgn_r && sa_r) begin
                    res_hi_s = neg_w(acc_r);
                end else begin
                    res_hi_s = acc_r;
                end
`endif
            end
        end else begin
`ifdef MULDIV_SIGNED_EN
            if (sgn_r && (sa_r ^ sb_r)) begin
                prod_s = neg_2w({acc_r, low_r});
            end else begin
                prod_s = {acc_r, low_r};
            end
`endif
            res_hi_s = prod_s[2*W-1:W];
            res_lo_s = prod_s[W-1:0];
            res_dz_s = 1'b0;
        end
    end

    // Sequencer FSM and work registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= {W{1'b0}};
            lo_r       <= {W{1'b0}};
            div_zero_r <= 1'b0;
            is_div_r   <= 1'b0;
            dz_r       <= 1'b0;
            acc_r      <= {W{1'b0}};
            low_r      <= {W{1'b0}};
            opb_r      <= {W{1'b0}};
            a_orig_r   <= {W{1'b0}};
            cnt_r      <= {CW{1'b0}};
`ifdef MULDIV_SIGNED_EN
            sgn_r      <= 1'b0;
            sa_r       <= 1'b0;
            sb_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r  <= ST_CALC;
                        busy_r   <= 1'b1;
                        is_div_r <= (op[1] == OP_DIVU[1]);
                        dz_r     <= (b == {W{1'b0}});
                        a_orig_r <= a;
                        acc_r    <= {W{1'b0}};
                        // Divide iterates on the dividend; multiply on the multiplier
                        low_r    <= op[1] ? mag_a_s : mag_b_s;
                        opb_r    <= op[1] ? mag_b_s : mag_a_s;
                        cnt_r    <= {CW{1'b0}};
`ifdef MULDIV_SIGNED_EN
                        sgn_r    <= op[0];
                        sa_r     <= a[W-1];
                        sb_r     <= b[W-1];
`endif
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_nx_s;
                    low_r <= low_nx_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    hi_r       <= res_hi_s;
                    lo_r       <= res_lo_s;
                    div_zero_r <= res_dz_s;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq (W=32); expected values follow
// MULDIV_SIGNED_EN when the bench is built with that macro.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int   n_tests;
    int   n_fail;
    res_t sb_q[$];

    muldiv_seq #(.W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        logic        sgn;
        logic [63:0] p;
        longint      sx;
        longint      sy;
        longint      q;
        longint      m;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.dz = 1'b0;
        if (o[1] == 1'b0) begin
            if (sgn) p = sx * sy;
            else     p = {32'd0, x} * {32'd0, y};
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (y == 32'd0) begin
            r.hi = x;
            r.lo = 32'hFFFF_FFFF;
            r.dz = 1'b1;
        end else if (sgn) begin
            q = sx / sy;
            m = sx % sy;
            r.hi = m[31:0];
            r.lo = q[31:0];
        end else begin
            r.hi = x % y;
            r.lo = x / y;
        end
        return r;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accept edge until done; optional stray start at cycle inject_at.
    task automatic wait_done(input int inject_at, input bit hold, output int cyc, output bit ovl);
        cyc = 0;
        ovl = 1'b0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done && busy) ovl = 1'b1;
            if (!hold) begin
                if (inject_at != 0 && cyc == inject_at) begin
                    start = 1'b1;
                    op    = OP_MULU;
                    a     = 32'd3;
                    b     = 32'd4;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, hi, lo, div_zero} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h dz=%b, required all zero", busy, done, hi, lo, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mulu();
        int cyc; bit ovl; res_t e;
        sb_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dz: 1'b0});
        issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mulu_busy_after_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done(0, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (cyc + 1 !== 34 || ovl) begin
            n_fail++;
            $display("FAIL mulu_latency: latency=%0d overlap=%b, required 34 and no overlap", cyc + 1, ovl);
        end
        n_tests++;
        if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL mulu_result: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b", hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || lo !== e.lo) begin
            n_fail++;
            $display("FAIL mulu_pulse_hold: done=%b busy=%b lo=%h, required done=0 busy=0 lo=%h", done, busy, lo, e.lo);
        end
    endtask

    task automatic test_mul_signed();
        int cyc; bit ovl; res_t e;
`ifdef MULDIV_SIGNED_EN
        sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dz: 1'b0});
`else
        sb_q.push_back('{hi: 32'h0000_0006, lo: 32'hFFFF_FFEB, dz: 1'b0});
`endif
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd7);
        wait_done(0, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (cyc + 1 !== 34 || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL mul_signed: lat=%0d hi=%h lo=%h dz=%b, required lat=34 hi=%h lo=%h dz=%b", cyc + 1, hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
    endtask

    task automatic test_divu();
        int cyc; bit ovl; res_t e;
        sb_q.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(0, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (cyc + 1 !== 34 || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL divu: lat=%0d hi=%h lo=%h dz=%b, required lat=34 hi=%h lo=%h dz=%b", cyc + 1, hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
    endtask

    task automatic test_div_signed();
        int cyc; bit ovl; res_t e;
`ifdef MULDIV_SIGNED_EN
        sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dz: 1'b0});
`else
        sb_q.push_back('{hi: 32'h0000_0001, lo: 32'h7FFF_FFFC, dz: 1'b0});
`endif
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL div_signed: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b", hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
    endtask

    task automatic test_div_zero();
        int cyc; bit ovl; res_t e;
        sb_q.push_back('{hi: 32'h0000_1234, lo: 32'hFFFF_FFFF, dz: 1'b1});
        issue(OP_DIVU, 32'h0000_1234, 32'd0);
        wait_done(0, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (cyc + 1 !== 34 || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL div_zero: lat=%0d hi=%h lo=%h dz=%b, required lat=34 hi=%h lo=%h dz=%b", cyc + 1, hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
    endtask

    task automatic test_overflow();
        int cyc; bit ovl; res_t e;
`ifdef MULDIV_SIGNED_EN
        sb_q.push_back('{hi: 32'h0000_0000, lo: 32'h8000_0000, dz: 1'b0});
`else
        sb_q.push_back('{hi: 32'h8000_0000, lo: 32'h0000_0000, dz: 1'b0});
`endif
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL div_overflow: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b", hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
    endtask

    task automatic test_random();
        int cyc; bit ovl; res_t e;
        logic [1:0] o; logic [31:0] x; logic [31:0] y;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if (i % 4 == 3) y = y & 32'h0000_00FF;
            sb_q.push_back(model(o, x, y));
            issue(o, x, y);
            wait_done(0, 1'b0, cyc, ovl);
            e = sb_q.pop_front();
            n_tests++;
            if (cyc + 1 !== 34 || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dz=%b, required lat=34 hi=%h lo=%h dz=%b",
                         i, o, x, y, cyc + 1, hi, lo, div_zero, e.hi, e.lo, e.dz);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc; bit ovl; bit saw; res_t e;
        sb_q.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(5, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (cyc + 1 !== 34 || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL busy_ignore_result: lat=%0d hi=%h lo=%h, required lat=34 hi=%h lo=%h", cyc + 1, hi, lo, e.hi, e.lo);
        end
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1'b1;
        end
        n_tests++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore_no_extra: activity=%b, required 0", saw);
        end
    endtask

    task automatic test_abort();
        int cyc; bit ovl; bit saw; res_t e;
        sb_q.push_back('{hi: 32'd0, lo: 32'd0, dz: 1'b0});
        issue(OP_MULU, 32'h0000_1234, 32'h0000_5678);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        n_tests++;
        if ({busy, done, hi, lo, div_zero} !== 67'd0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h dz=%b, required all zero", busy, done, hi, lo, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1'b1;
        end
        n_tests++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: activity=%b, required 0", saw);
        end
        sb_q.push_back('{hi: 32'd0, lo: 32'd12, dz: 1'b0});
        issue(OP_MULU, 32'd3, 32'd4);
        wait_done(0, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (cyc + 1 !== 34 || hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL abort_then_mulu: lat=%0d hi=%h lo=%h, required lat=34 hi=%h lo=%h", cyc + 1, hi, lo, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit ovl; res_t e;
        sb_q.push_back('{hi: 32'd0, lo: 32'd30, dz: 1'b0});
        sb_q.push_back('{hi: 32'd0, lo: 32'd63, dz: 1'b0});
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULU;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        #1;
        a = 32'd7;
        b = 32'd9;
        wait_done(0, 1'b1, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (cyc + 1 !== 34 || ovl || hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d ovl=%b hi=%h lo=%h, required lat=34 hi=%h lo=%h", cyc + 1, ovl, hi, lo, e.hi, e.lo);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done(0, 1'b0, cyc, ovl);
        e = sb_q.pop_front();
        n_tests++;
        if (cyc + 1 !== 34 || ovl || hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d ovl=%b hi=%h lo=%h, required lat=34 hi=%h lo=%h", cyc + 1, ovl, hi, lo, e.hi, e.lo);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_mulu();
        test_mul_signed();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_random();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
